// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - round-robin SDRAM port arbiter with host priority, quota and watchdog
module sdram_port_arbiter #(
    parameter int MAX_XFER  = 8,
    parameter int TIMEOUT   = 1024,
    parameter int GAP_CYC   = 3,
    parameter int HOST_PRIO = 1
) (
    input  logic       iCLK,
    input  logic       iRST_n,
    input  logic [3:0] iREQ,
    input  logic       iSDR_Done,
    output logic [1:0] oSelect,
    output logic [3:0] oGNT,
    output logic       oBusy,
    output logic       oTimeout
);

    localparam int XW = (MAX_XFER > 1) ? $clog2(MAX_XFER) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int GW = $clog2(GAP_CYC + 1);

    localparam logic [XW-1:0] XFER_LAST = XW'(MAX_XFER - 1);
    localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYC - 1);

    typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

    state_t          state;
    logic [1:0]      rr_ptr;
    logic [XW-1:0]   xfer_cnt;
    logic [WW-1:0]   wd_cnt;
    logic [GW-1:0]   gap_cnt;

    logic [1:0]      winner;
    logic [1:0]      cand;
    logic            found;
    logic            others_req;

    // Scan rr_ptr+1 .. rr_ptr+4 so the last owner is considered last.
    always_comb begin
        winner = rr_ptr;
        cand   = rr_ptr;
        found  = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cand = rr_ptr + 2'(i);
            if (!found && iREQ[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
        if (HOST_PRIO != 0 && iREQ[0]) begin
            winner = 2'd0;
        end
    end

    // In OWN the grant is one-hot on the owner, so masking it leaves the waiting ports.
    assign others_req = |(iREQ & ~oGNT);

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state    <= IDLE;
            oSelect  <= 2'd0;
            oGNT     <= 4'd0;
            oBusy    <= 1'b0;
            oTimeout <= 1'b0;
            rr_ptr   <= 2'd0;
            xfer_cnt <= '0;
            wd_cnt   <= '0;
            gap_cnt  <= '0;
        end else begin
            oTimeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (iREQ != 4'd0) begin
                        state    <= OWN;
                        oGNT     <= 4'd1 << winner;
                        oSelect  <= winner;
                        oBusy    <= 1'b1;
                        rr_ptr   <= winner;
                        xfer_cnt <= '0;
                        wd_cnt   <= '0;
                    end
                end
                OWN: begin
                    if (!iREQ[oSelect]) begin
                        state   <= GAP;
                        oGNT    <= 4'd0;
                        gap_cnt <= '0;
                    end else if (iSDR_Done && xfer_cnt == XFER_LAST && others_req) begin
                        state   <= GAP;
                        oGNT    <= 4'd0;
                        gap_cnt <= '0;
                    end else if (iSDR_Done) begin
                        if (xfer_cnt != XFER_LAST) begin
                            xfer_cnt <= xfer_cnt + 1'b1;
                        end
                        wd_cnt <= '0;
                    end else if (wd_cnt == WD_LAST) begin
                        state    <= GAP;
                        oGNT     <= 4'd0;
                        gap_cnt  <= '0;
                        oTimeout <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                        oBusy <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    oGNT  <= 4'd0;
                    oBusy <= 1'b0;
                end
            endcase
        end
    end

endmodule
